// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, functs,
// ALU_control codes, ALU-op selector and the FSM state enum.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [2:0] ALUC_ADD = 3'b010;
    localparam logic [2:0] ALUC_SUB = 3'b110;
    localparam logic [2:0] ALUC_AND = 3'b000;
    localparam logic [2:0] ALUC_OR  = 3'b001;
    localparam logic [2:0] ALUC_SLT = 3'b111;

    typedef enum logic [1:0] {
        ALU_OP_ADD   = 2'b00,
        ALU_OP_SUB   = 2'b01,
        ALU_OP_FUNCT = 2'b10
    } alu_op_t;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEXEC = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11
    } state_t;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU-op/funct to ALU_control mapping; flags functs the
// datapath does not implement (they fall back to add).
module alu_decoder
    import mips_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alu_control,
    output logic       funct_illegal
);

    always_comb begin
        alu_control   = ALUC_ADD;
        funct_illegal = 1'b0;
        case (alu_op)
            ALU_OP_ADD: alu_control = ALUC_ADD;
            ALU_OP_SUB: alu_control = ALUC_SUB;
            ALU_OP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: alu_control = ALUC_ADD;
                    FUNCT_SUB: alu_control = ALUC_SUB;
                    FUNCT_AND: alu_control = ALUC_AND;
                    FUNCT_OR:  alu_control = ALUC_OR;
                    FUNCT_SLT: alu_control = ALUC_SLT;
                    default:   funct_illegal = 1'b1;
                endcase
            end
            default: alu_control = ALUC_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control unit: Moore FSM, retired-instruction counter, sticky
// illegal flag. Define MULTICYCLE_BNE_EN to compile in bne (Op_code 000101).
module multicycle_controller
    import mips_pkg::*;
#(
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         Op_code,
    input  logic [5:0]         Funct,
    input  logic               zero,
    output logic               IorD,
    output logic               IR_write,
    output logic               Mem_write,
    output logic               Reg_dst,
    output logic               Memtoreg,
    output logic               Reg_write,
    output logic               ALU_srcA,
    output logic               Branch,
    output logic               PC_write,
    output logic [1:0]         ALU_srcB,
    output logic [1:0]         PC_src,
    output logic [2:0]         ALU_control,
    output logic               PC_en,
    output logic               instr_done,
    output logic               illegal_op,
    output logic [COUNT_W-1:0] instr_count,
    output state_t             state
);

    state_t             state_q, state_d;
    alu_op_t            alu_op;
    logic               funct_illegal;
    logic               illegal_decode;
    logic               branch_cond;
    logic               illegal_q;
    logic [COUNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH: state_d = DECODE;
            DECODE: begin
                case (Op_code)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEXEC;
                    OP_J:         state_d = JUMP;
`ifdef MULTICYCLE_BNE_EN
                    OP_BNE:       state_d = BRANCH;
`endif
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR:   state_d = (Op_code == OP_LW) ? MEMRD : MEMWR;
            MEMRD:    state_d = MEMWB;
            EXECUTE:  state_d = ALUWB;
            ADDIEXEC: state_d = ADDIWB;
            default:  state_d = FETCH;
        endcase
    end

    // The only way DECODE falls straight back to FETCH is an unsupported opcode.
    assign illegal_decode = (state_q == DECODE) && (state_d == FETCH);

`ifdef MULTICYCLE_BNE_EN
    logic is_bne_q;

    always_ff @(posedge clk) begin
        if (reset)                  is_bne_q <= 1'b0;
        else if (state_q == DECODE) is_bne_q <= (Op_code == OP_BNE);
    end

    assign branch_cond = zero ^ is_bne_q;
`else
    assign branch_cond = zero;
`endif

    always_comb begin
        IorD       = 1'b0;
        IR_write   = 1'b0;
        Mem_write  = 1'b0;
        Reg_dst    = 1'b0;
        Memtoreg   = 1'b0;
        Reg_write  = 1'b0;
        ALU_srcA   = 1'b0;
        Branch     = 1'b0;
        PC_write   = 1'b0;
        ALU_srcB   = 2'b00;
        PC_src     = 2'b00;
        alu_op     = ALU_OP_ADD;
        instr_done = 1'b0;
        case (state_q)
            FETCH: begin
                IR_write = 1'b1;
                PC_write = 1'b1;
                ALU_srcB = 2'b01;
            end
            DECODE: ALU_srcB = 2'b11;
            MEMADR, ADDIEXEC: begin
                ALU_srcA = 1'b1;
                ALU_srcB = 2'b10;
            end
            MEMRD: IorD = 1'b1;
            MEMWB: begin
                Memtoreg   = 1'b1;
                Reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            MEMWR: begin
                IorD       = 1'b1;
                Mem_write  = 1'b1;
                instr_done = 1'b1;
            end
            EXECUTE: begin
                ALU_srcA = 1'b1;
                alu_op   = ALU_OP_FUNCT;
            end
            ALUWB: begin
                Reg_dst    = 1'b1;
                Reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            BRANCH: begin
                ALU_srcA   = 1'b1;
                alu_op     = ALU_OP_SUB;
                PC_src     = 2'b01;
                Branch     = 1'b1;
                instr_done = 1'b1;
            end
            ADDIWB: begin
                Reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            JUMP: begin
                PC_src     = 2'b10;
                PC_write   = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
        // Reset aborts whatever is in flight without any architectural write.
        if (reset) begin
            IR_write   = 1'b0;
            PC_write   = 1'b0;
            Mem_write  = 1'b0;
            Reg_write  = 1'b0;
            instr_done = 1'b0;
        end
        PC_en = PC_write | (Branch & branch_cond);
    end

    alu_decoder u_alu_decoder (
        .alu_op        (alu_op),
        .funct         (Funct),
        .alu_control   (ALU_control),
        .funct_illegal (funct_illegal)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            illegal_q <= 1'b0;
            count_q   <= '0;
        end else begin
            if (illegal_decode || (state_q == EXECUTE && funct_illegal))
                illegal_q <= 1'b1;
            if (instr_done || illegal_decode)
                count_q <= count_q + COUNT_W'(1);
        end
    end

    assign illegal_op  = illegal_q;
    assign instr_count = count_q;
    assign state       = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: directed instructions push
// expected per-cycle control words; a negedge monitor pops and compares.
module tb_multicycle_controller;
    import mips_pkg::*;

    localparam int W = 27;

    logic       clk, reset, zero;
    logic [5:0] Op_code, Funct;
    logic       IorD, IR_write, Mem_write, Reg_dst, Memtoreg, Reg_write;
    logic       ALU_srcA, Branch, PC_write, PC_en, instr_done, illegal_op;
    logic [1:0] ALU_srcB, PC_src;
    logic [2:0] ALU_control;
    logic [3:0] instr_count;
    state_t     state;

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           checks = 0;
    int           errors = 0;
    logic         mon_en = 1'b0;
    logic [3:0]   m_count = 4'd0;
    logic         m_illegal = 1'b0;

    multicycle_controller #(.COUNT_W(4)) dut (
        .clk(clk), .reset(reset), .Op_code(Op_code), .Funct(Funct), .zero(zero),
        .IorD(IorD), .IR_write(IR_write), .Mem_write(Mem_write), .Reg_dst(Reg_dst),
        .Memtoreg(Memtoreg), .Reg_write(Reg_write), .ALU_srcA(ALU_srcA),
        .Branch(Branch), .PC_write(PC_write), .ALU_srcB(ALU_srcB), .PC_src(PC_src),
        .ALU_control(ALU_control), .PC_en(PC_en), .instr_done(instr_done),
        .illegal_op(illegal_op), .instr_count(instr_count), .state(state)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [2:0] exp_funct(input logic [5:0] fn);
        case (fn)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Expected control word for one cycle, straight from the per-state table.
    function automatic logic [W-1:0] exp_word(input state_t s, input logic [5:0] fn,
                                              input logic z, input logic bne,
                                              input logic [3:0] cnt, input logic ill,
                                              input logic done);
        logic iord, irw, memw, regd, mtr, regw, srca, br, pcw, pce;
        logic [1:0] srcb, pcs;
        logic [2:0] aluc;
        iord = 0; irw = 0; memw = 0; regd = 0; mtr = 0; regw = 0;
        srca = 0; br = 0; pcw = 0; srcb = 2'b00; pcs = 2'b00; aluc = 3'b010;
        case (s)
            FETCH:            begin irw = 1; pcw = 1; srcb = 2'b01; end
            DECODE:           srcb = 2'b11;
            MEMADR, ADDIEXEC: begin srca = 1; srcb = 2'b10; end
            MEMRD:            iord = 1;
            MEMWB:            begin mtr = 1; regw = 1; end
            MEMWR:            begin iord = 1; memw = 1; end
            EXECUTE:          begin srca = 1; aluc = exp_funct(fn); end
            ALUWB:            begin regd = 1; regw = 1; end
            BRANCH:           begin srca = 1; aluc = 3'b110; pcs = 2'b01; br = 1; end
            ADDIWB:           regw = 1;
            JUMP:             begin pcs = 2'b10; pcw = 1; end
            default: ;
        endcase
        pce = pcw | (br & (z ^ bne));
        return {s, iord, irw, memw, regd, mtr, regw, srca, br, pcw,
                srcb, pcs, aluc, pce, done, ill, cnt};
    endfunction

    // scoreboard monitor
    always @(negedge clk) begin
        logic [W-1:0] act, exp;
        string nm;
        if (mon_en) begin
            act = {state, IorD, IR_write, Mem_write, Reg_dst, Memtoreg, Reg_write,
                   ALU_srcA, Branch, PC_write, ALU_srcB, PC_src, ALU_control,
                   PC_en, instr_done, illegal_op, instr_count};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL underflow got %h exp nothing", act);
            end else begin
                exp = exp_q.pop_front();
                nm  = name_q.pop_front();
                if (act !== exp) begin
                    errors++;
                    $display("FAIL %s got %h exp %h", nm, act, exp);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", nm, act, exp);
        end
    endtask

    // Driver: called at posedge+1 of a FETCH cycle, returns at posedge+1 of the next FETCH.
    task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic z,
                         input string nm);
        state_t seq[$];
        logic legal, bad_fn, bne;
        Op_code = op;
        Funct   = fn;
        zero    = z;
        legal   = 1'b1;
        bne     = 1'b0;
        seq.push_back(FETCH);
        seq.push_back(DECODE);
        case (op)
            6'b100011: begin seq.push_back(MEMADR); seq.push_back(MEMRD); seq.push_back(MEMWB); end
            6'b101011: begin seq.push_back(MEMADR); seq.push_back(MEMWR); end
            6'b000000: begin seq.push_back(EXECUTE); seq.push_back(ALUWB); end
            6'b000100: seq.push_back(BRANCH);
            6'b001000: begin seq.push_back(ADDIEXEC); seq.push_back(ADDIWB); end
            6'b000010: seq.push_back(JUMP);
`ifdef MULTICYCLE_BNE_EN
            6'b000101: begin seq.push_back(BRANCH); bne = 1'b1; end
`endif
            default: legal = 1'b0;
        endcase
        bad_fn = (op == 6'b000000) &&
                 !(fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010});
        for (int i = 0; i < seq.size(); i++) begin
            exp_q.push_back(exp_word(seq[i], fn, z, bne, m_count, m_illegal,
                                     legal && (i == seq.size() - 1)));
            name_q.push_back($sformatf("%s_c%0d", nm, i + 1));
            if (seq[i] == DECODE && !legal) begin
                m_count++;
                m_illegal = 1'b1;
            end
            if (seq[i] == EXECUTE && bad_fn) m_illegal = 1'b1;
        end
        if (legal) m_count++;
        mon_en = 1'b1;
        repeat (seq.size()) @(posedge clk);
        #1;
    endtask

    initial begin
        reset   = 1'b1;
        Op_code = 6'b100011;
        Funct   = 6'b000000;
        zero    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", 32'(state), 32'(FETCH));
        chk("rst_strobes", {IR_write, PC_write, PC_en, Mem_write, Reg_write}, 0);
        chk("rst_count", instr_count, 0);
        chk("rst_illegal", illegal_op, 0);
        reset = 1'b0;

        issue(6'b100011, 6'b000000, 1'b0, "lw");
        issue(6'b000000, 6'b101010, 1'b0, "slt");
        issue(6'b000100, 6'b000000, 1'b1, "beq_taken");
        issue(6'b000100, 6'b000000, 1'b0, "beq_not");
        issue(6'b101011, 6'b000000, 1'b0, "sw");
        issue(6'b001000, 6'b000000, 1'b1, "addi");
        issue(6'b000000, 6'b100000, 1'b0, "add");
        issue(6'b000000, 6'b100010, 1'b0, "sub");
        issue(6'b000000, 6'b100100, 1'b0, "and");
        issue(6'b000000, 6'b100101, 1'b0, "or");
        issue(6'b000000, 6'b000111, 1'b0, "bad_funct");
        mon_en = 1'b0;

        // Reset asserted in the MEMWR cycle of a store.
        Op_code = 6'b101011;
        repeat (3) @(posedge clk);
        #1;
        chk("mwr_state", 32'(state), 32'(MEMWR));
        chk("mwr_memwrite_pre", Mem_write, 1);
        reset = 1'b1;
        #1;
        chk("mwr_memwrite_rst", Mem_write, 0);
        @(posedge clk);
        #1;
        chk("mwr_abort_state", 32'(state), 32'(FETCH));
        chk("mwr_abort_count", instr_count, 0);
        chk("mwr_abort_illegal", illegal_op, 0);
        m_count   = 4'd0;
        m_illegal = 1'b0;
        reset = 1'b0;

        issue(6'b111111, 6'b000000, 1'b0, "illegal");
        issue(6'b100011, 6'b000000, 1'b0, "lw2");
        issue(6'b101011, 6'b000000, 1'b0, "sw2");
        issue(6'b000010, 6'b000000, 1'b0, "j");
        issue(6'b000100, 6'b000000, 1'b0, "beq2");
        issue(6'b001000, 6'b000000, 1'b0, "addi2");
        issue(6'b000101, 6'b000000, 1'b0, "bne");
        for (int k = 0; k < 10; k++) issue(6'b000010, 6'b000000, 1'b0, $sformatf("jwrap%0d", k));
        mon_en = 1'b0;
        chk("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
